// File: rtl/preempt_scheduler.sv
// preempt_scheduler
//   Round-robin context-switch controller. It drives the preemption timer
//   (timer_rw) and consumes its expiry flag and captured PC. A small process
//   table holds a saved PC and a valid bit per slot. When a quantum expires,
//   the controller saves the interrupted PC and picks the next valid process.
//   It then issues a PC load to fetch and re-arms the timer.
//
// Optional build macro: SCHED_STATS_EN adds the switch_count output.
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   halt           : freeze; all state holds and command outputs read 0
//   sched_en       : allows leaving IDLE (sampled only in IDLE)
//   spawn/spawn_pc : create a process in the lowest free slot
//   kill           : running process terminates (RUN only)
//   timer_finish   : quantum-expired flag from the timer
//   timer_pc       : PC captured by the timer at expiry
//   timer_rw       : timer command; 11 arm, 01 stop, 00 idle
//   pc_load        : strobe, fetch jumps to pc_next
//   pc_next        : PC to load
//   cur_pid        : running process id
//   busy           : context switch in progress (SAVE/PICK/LOAD/ARM)
//   err_full       : spawn rejected because the table is full
//   switch_count   : (SCHED_STATS_EN) number of pc_load strobes, wrapping
//
// Handshake: there is no back-pressure. pc_load and err_full are one-cycle
// strobes. timer_rw is a command that is valid in the cycle it reads
// non-zero. All three are registered and gated to zero while halt is high.
// A strobe held by halt is presented on the first cycle after release.
module preempt_scheduler #(
  parameter int NPROC = 4,
  parameter int PIDW  = 2,
  parameter int PCW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            sched_en,
  input  logic            spawn,
  input  logic [PCW-1:0]  spawn_pc,
  input  logic            kill,
  input  logic            timer_finish,
  input  logic [PCW-1:0]  timer_pc,
  output logic [1:0]      timer_rw,
  output logic            pc_load,
  output logic [PCW-1:0]  pc_next,
  output logic [PIDW-1:0] cur_pid,
  output logic            busy,
  output logic            err_full
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]     switch_count
`endif
);

  typedef enum logic [2:0] {IDLE, PICK, LOAD, ARM, RUN, SAVE} state_t;

  state_t           state, state_n;
  logic [NPROC-1:0] valid, valid_n;
  logic [PCW-1:0]   pc_tab [NPROC];
  logic             finish_q;
  logic [1:0]       rw_q, rw_n;
  logic             load_q, load_n;
  logic             err_q;
  logic [PIDW-1:0]  pid_n;
  logic [PCW-1:0]   pc_next_n;
  logic             kill_apply, save_en, expiry;
  logic             found, free_found;
  logic [PIDW-1:0]  winner, cand, free_idx;

  assign expiry = timer_finish & ~finish_q;

  // Scan cur_pid+1 .. cur_pid+NPROC. The last candidate wraps to cur_pid,
  // so the running process is only reselected when it is the sole valid one.
  always_comb begin
    found  = 1'b0;
    winner = cur_pid;
    cand   = '0;
    for (int i = 1; i <= NPROC; i++) begin
      cand = cur_pid + PIDW'(i);
      if (!found && valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Lowest free slot, taken from the table as it stands before this edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (!free_found && !valid[i]) begin
        free_found = 1'b1;
        free_idx   = PIDW'(i);
      end
    end
  end

  // Next state. Command outputs are computed for the state being entered.
  // They then appear, registered, during that state.
  always_comb begin
    state_n    = state;
    rw_n       = 2'b00;
    load_n     = 1'b0;
    pid_n      = cur_pid;
    pc_next_n  = pc_next;
    kill_apply = 1'b0;
    save_en    = 1'b0;
    case (state)
      IDLE: if (sched_en && |valid) state_n = PICK;
      PICK: begin
        if (found) begin
          pid_n     = winner;
          pc_next_n = pc_tab[winner];
          load_n    = 1'b1;
          state_n   = LOAD;
        end else begin
          rw_n    = 2'b01;
          state_n = IDLE;
        end
      end
      LOAD: begin
        rw_n    = 2'b11;
        state_n = ARM;
      end
      ARM:  state_n = RUN;
      RUN: begin
        // kill beats a simultaneous expiry; the killed PC is not saved
        if (kill) begin
          kill_apply = 1'b1;
          rw_n       = 2'b01;
          state_n    = PICK;
        end else if (expiry) begin
          rw_n    = 2'b01;
          state_n = SAVE;
        end
      end
      SAVE: begin
        save_en = 1'b1;
        state_n = PICK;
      end
      default: state_n = IDLE;
    endcase
  end

  // kill and spawn may both apply. The spawn slot comes from the pre-edge
  // table, so it can never be the slot that this kill frees.
  always_comb begin
    valid_n = valid;
    if (kill_apply) valid_n[cur_pid] = 1'b0;
    if (spawn && free_found) valid_n[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      cur_pid  <= PIDW'(NPROC - 1);
      pc_next  <= '0;
      rw_q     <= 2'b00;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
      for (int i = 0; i < NPROC; i++) pc_tab[i] <= '0;
    end else if (!halt) begin
      state    <= state_n;
      valid    <= valid_n;
      cur_pid  <= pid_n;
      pc_next  <= pc_next_n;
      rw_q     <= rw_n;
      load_q   <= load_n;
      err_q    <= spawn & ~free_found;
      finish_q <= timer_finish;
      if (save_en) pc_tab[cur_pid] <= timer_pc;
      if (spawn && free_found) pc_tab[free_idx] <= spawn_pc;
    end
  end

  assign timer_rw = halt ? 2'b00 : rw_q;
  assign pc_load  = load_q & ~halt;
  assign err_full = err_q & ~halt;
  assign busy     = (state == SAVE) || (state == PICK) ||
                    (state == LOAD) || (state == ARM);

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) switch_count <= '0;
    else if (pc_load) switch_count <= switch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_preempt_scheduler.sv
// tb_preempt_scheduler
//   Directed bench for preempt_scheduler. Stimulus pushes expected pc_load
//   {pid, pc}, timer_rw commands and err_full pulses into queues. A monitor
//   pops and compares them whenever the DUT presents the output.
module tb_preempt_scheduler;
  localparam int NPROC = 4;
  localparam int PIDW  = 2;
  localparam int PCW   = 32;

  logic            clk = 1'b0;
  logic            reset, halt, sched_en, spawn, kill, timer_finish;
  logic [PCW-1:0]  spawn_pc, timer_pc, pc_next;
  logic [1:0]      timer_rw;
  logic            pc_load, busy, err_full;
  logic [PIDW-1:0] cur_pid;
`ifdef SCHED_STATS_EN
  logic [31:0]     switch_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_sw = 0;

  logic [PIDW+PCW-1:0] load_q[$];
  logic [1:0]          rw_q[$];
  logic                err_q[$];

  preempt_scheduler #(.NPROC(NPROC), .PIDW(PIDW), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .halt(halt), .sched_en(sched_en),
    .spawn(spawn), .spawn_pc(spawn_pc), .kill(kill),
    .timer_finish(timer_finish), .timer_pc(timer_pc),
    .timer_rw(timer_rw), .pc_load(pc_load), .pc_next(pc_next),
    .cur_pid(cur_pid), .busy(busy), .err_full(err_full)
`ifdef SCHED_STATS_EN
    , .switch_count(switch_count)
`endif
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_load(input logic [PIDW-1:0] pid, input logic [PCW-1:0] pc);
    load_q.push_back({pid, pc});
    rw_q.push_back(2'b11);
    exp_sw++;
  endtask

  task automatic run_monitor();
    logic [PIDW+PCW-1:0] e;
    forever begin
      @(negedge clk);
      if (pc_load) begin
        if (load_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got pid %0d pc 0x%0h, required no load", cur_pid, pc_next);
        end else begin
          e = load_q.pop_front();
          check("load_pid", 64'(cur_pid), 64'(e[PCW +: PIDW]));
          check("load_pc", 64'(pc_next), 64'(e[PCW-1:0]));
        end
      end
      if (timer_rw != 2'b00) begin
        if (rw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rw: got %b, required 00", timer_rw);
        end else begin
          check("timer_rw", 64'(timer_rw), 64'(rw_q.pop_front()));
        end
      end
      if (err_full) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err_full: got 1, required 0");
        end else begin
          check("err_full", 64'(err_full), 64'(err_q.pop_front()));
        end
      end
    end
  endtask

  // Counts cycles from the current one until pc_load is seen at a negedge.
  task automatic wait_load(input int lat, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      if (pc_load) seen = 1'b1;
      else n++;
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
    if (seen) check(name, 64'(n), 64'(lat));
  endtask

  // From the LOAD-cycle negedge: check the ARM command, end in RUN.
  task automatic to_run();
    tick();
    @(negedge clk);
    check("arm_rw", 64'(timer_rw), 64'(2'b11));
    check("arm_busy", 64'(busy), 64'd1);
    tick();
  endtask

  task automatic pulse_finish(input logic [PCW-1:0] pc);
    timer_finish = 1'b1;
    timer_pc = pc;
    tick();
    timer_finish = 1'b0;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; sched_en = 1'b0; spawn = 1'b0; kill = 1'b0;
    timer_finish = 1'b0; spawn_pc = '0; timer_pc = '0;
    fork
      run_monitor();
    join_none

    // reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_rw", 64'(timer_rw), 64'd0);
    check("rst_load", 64'(pc_load), 64'd0);
    check("rst_pc_next", 64'(pc_next), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_full), 64'd0);
    check("rst_cur_pid", 64'(cur_pid), 64'(NPROC - 1));
`ifdef SCHED_STATS_EN
    check("rst_switch_count", 64'(switch_count), 64'd0);
`endif
    tick();
    reset = 1'b0;

    // two processes, first schedule
    spawn = 1'b1; spawn_pc = 32'h100;
    tick();
    spawn_pc = 32'h200;
    tick();
    spawn = 1'b0; sched_en = 1'b1;
    push_load(2'd0, 32'h100);
    wait_load(2, "first_load_lat");
    to_run();

    // expiry on pid 0: save 0x120, switch to pid 1
    rw_q.push_back(2'b01);
    push_load(2'd1, 32'h200);
    pulse_finish(32'h120);
    wait_load(2, "expiry_load_lat");
    to_run();

    // expiry on pid 1: wraps to pid 0 with its saved PC
    rw_q.push_back(2'b01);
    push_load(2'd0, 32'h120);
    pulse_finish(32'h240);
    wait_load(2, "wrap_load_lat");
    to_run();

    // kill and expiry together on pid 0: kill wins, no save
    rw_q.push_back(2'b01);
    push_load(2'd1, 32'h240);
    kill = 1'b1; timer_finish = 1'b1; timer_pc = 32'hDEAD;
    tick();
    kill = 1'b0; timer_finish = 1'b0;
    wait_load(1, "kill_load_lat");
    to_run();

    // kill the last process: stop from the kill, stop again from empty PICK
    rw_q.push_back(2'b01);
    rw_q.push_back(2'b01);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_last_kill", 64'(busy), 64'd0);
    check("rw_drained_after_kill", 64'(rw_q.size()), 64'd0);

    // five spawns into four slots
    tick();
    sched_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) err_q.push_back(1'b1);
      spawn = 1'b1;
      spawn_pc = 32'hA00 + 32'(i) * 32'h100;
      tick();
    end
    spawn = 1'b0;
    @(negedge clk);
    check("err_full_pulse", 64'(err_full), 64'd1);
    tick();
    @(negedge clk);
    check("err_full_one_cycle", 64'(err_full), 64'd0);

    // cur_pid is 1, so scheduling resumes at pid 2
    tick();
    sched_en = 1'b1;
    push_load(2'd2, 32'hC00);
    wait_load(2, "resume_load_lat");
    to_run();

    // kill plus spawn with a full table: the freed slot is not reused
    rw_q.push_back(2'b01);
    err_q.push_back(1'b1);
    push_load(2'd3, 32'hD00);
    kill = 1'b1; spawn = 1'b1; spawn_pc = 32'hF00;
    tick();
    kill = 1'b0; spawn = 1'b0;
    wait_load(1, "kill_spawn_load_lat");
    to_run();

    // halt for 4 cycles while in LOAD
    rw_q.push_back(2'b01);
    push_load(2'd0, 32'hA00);
    pulse_finish(32'hD40);
    tick();
    tick();
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_no_load", 64'(pc_load), 64'd0);
      check("halt_busy", 64'(busy), 64'd1);
`ifdef SCHED_STATS_EN
      check("halt_switch_count", 64'(switch_count), 64'(exp_sw - 1));
`endif
      tick();
    end
    halt = 1'b0;
    wait_load(0, "halt_release_load");
    to_run();
`ifdef SCHED_STATS_EN
    check("switch_count_after_halt", 64'(switch_count), 64'(exp_sw));
`endif

    // pid 0 -> pid 1, then pid 1 -> skip killed pid 2 -> pid 3 with saved PC
    rw_q.push_back(2'b01);
    push_load(2'd1, 32'hB00);
    pulse_finish(32'hA40);
    wait_load(2, "pid1_load_lat");
    to_run();
    rw_q.push_back(2'b01);
    push_load(2'd3, 32'hD40);
    pulse_finish(32'hB40);
    wait_load(2, "skip_load_lat");
    to_run();

    // reset in the middle of a switch
    rw_q.push_back(2'b01);
    pulse_finish(32'h111);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_rw", 64'(timer_rw), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cur_pid", 64'(cur_pid), 64'(NPROC - 1));
    check("midrst_pc_next", 64'(pc_next), 64'd0);
`ifdef SCHED_STATS_EN
    check("midrst_switch_count", 64'(switch_count), 64'd0);
`endif
    tick();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("table_cleared_idle", 64'(busy), 64'd0);

    check("load_q_empty", 64'(load_q.size()), 64'd0);
    check("rw_q_empty", 64'(rw_q.size()), 64'd0);
    check("err_q_empty", 64'(err_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
